trap_ctl: RTL and testbench
===========================

# trap_ctl

Machine-mode trap sequencer for the five-stage pipeline. Watches the instruction in the MEM stage for `ecall`/`mret`, plus an optional external interrupt. On a trap it updates the trap CSRs, issues the exception flush consumed by IF_ID, ID_EX and EX_MEM, and hands a redirect target to fetch over a valid/ready handshake. It is the producer end of the exception-flush path that the pipeline registers consume.

## Interface
- `RESET_MTVEC`, default 32'h0000_0100: value loaded into mtvec on reset.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_valid_m` in 1: MEM stage holds a real (non-bubble) instruction.
- `i_pc_m` in 32: PC of the MEM-stage instruction.
- `i_ecall_m` in 1: MEM-stage instruction is `ecall`.
- `i_mret_m` in 1: MEM-stage instruction is `mret`.
- `i_csr_wr_m` in 1: MEM-stage CSR write enable.
- `i_csr_addr_m` in 12: CSR address.
- `i_csr_wdata_m` in 32: CSR write data.
- `i_ext_irq` in 1: level external interrupt request.
- `i_redirect_ready` in 1: fetch accepts the redirect.
- `o_flush_exception` out 1: flush IF_ID, ID_EX and EX_MEM.
- `o_stall` out 1: freeze fetch; drives pipeline clk_en low.
- `o_redirect_valid` out 1: redirect target is valid.
- `o_redirect_pc` out 32: target PC.
- `o_mtvec`, `o_mepc`, `o_mcause` out 32 each: CSR values, readable by decode.
- `o_mstatus` out 32: bit 3 = MIE, bit 7 = MPIE, all other bits 0.

## Operation
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE sample priority, highest first, all gated by `i_valid_m`:
  - `mret`: target = mepc; MIE ← MPIE; MPIE ← 1; go to FLUSH.
  - `ecall`: mepc ← `i_pc_m`; mcause ← 11; MPIE ← MIE; MIE ← 0; target = mtvec; go to FLUSH.
  - Interrupt, taken when irq is enabled, `i_ext_irq`=1 and MIE=1: mepc ← `i_pc_m`, so the instruction is flushed and re-executed; mcause ← 32'h8000_000B; MPIE ← MIE; MIE ← 0; target = mtvec; go to FLUSH.
  - Otherwise, CSR write when `i_csr_wr_m` is set:
    - 0x300 sets MIE/MPIE from wdata[3]/[7].
    - 0x305 sets mtvec = {wdata[31:2], 2'b00}.
    - 0x341 sets mepc = {wdata[31:2], 2'b00}.
    - 0x342 sets mcause.
    - Other addresses are ignored.
- A CSR write in the same cycle as a trap is dropped; the trap wins.
- `ecall` and `mret` together: `mret` wins. This is illegal encoding and is not checked.
- `i_valid_m`=0 in IDLE: nothing happens. A pending interrupt waits for the next valid instruction.
- FLUSH: `o_flush_exception`=1 and `o_stall`=1. Latch the target into `o_redirect_pc`. Always go to REDIRECT after 1 cycle.
- REDIRECT: `o_redirect_valid`=1 and `o_stall`=1, with `o_redirect_pc` stable. Stay until `i_redirect_ready` is sampled high, then go to IDLE.
- In FLUSH and REDIRECT, all ecall/mret/irq/CSR inputs are ignored; the pipeline is being flushed.

## Timing
- All outputs are registered. Reset values:
  - `o_flush_exception`, `o_stall`, `o_redirect_valid`, `o_redirect_pc`, `o_mepc`, `o_mcause`, `o_mstatus` = 0.
  - `o_mtvec` = `RESET_MTVEC`.
  - State = IDLE.
- Trap sampled at edge N:
  - CSRs update at edge N.
  - Flush is high for exactly the cycle between N and N+1.
  - `o_redirect_valid` rises after N+1.
- With ready held high, the redirect is accepted at edge N+2 and the block is back in IDLE after N+2. Minimum spacing between two traps is 3 cycles.
- `i_redirect_ready` during IDLE or FLUSH has no effect.
- Asynchronous reset mid-FLUSH or mid-REDIRECT: immediate return to IDLE, all outputs to reset values, and the redirect is abandoned.

## Configuration
- `TRAP_CTL_IRQ_EN` defined: the external-interrupt path is compiled in as described.
- Undefined: `i_ext_irq` is ignored and the interrupt path is removed. MIE/MPIE are still stored, readable and swapped by ecall/mret.

## Test plan
- Reset with `RESET_MTVEC`=0x100 → `o_mtvec`=0x100; all other outputs 0; state IDLE.
- `ecall` at pc 0x40, MIE=1, ready held 1 → mepc=0x40, mcause=11, mstatus=0x80. Flush high 1 cycle, then `o_redirect_valid`=1 with `o_redirect_pc`=0x100 for 1 cycle, then IDLE.
- Follow with `mret`, ready held 0 for 3 cycles → `o_redirect_pc`=0x40 held stable with valid high for 4 cycles; mstatus=0x88 after the mret edge.
- CSR write 0x305 with wdata 0x203, then `ecall` → mtvec=0x200 and redirect 0x200. CSR write 0x305 coincident with an `ecall` → write dropped, mtvec unchanged.
- Irq enabled: `i_ext_irq`=1 with MIE=1 at valid pc 0x80 → mcause=0x8000000B, mepc=0x80. Same with `i_valid_m`=0 → no trap until valid. Irq disabled → never taken.
- Assert `i_rst` during REDIRECT → valid drops immediately; next `ecall` is handled normally.

Source files
------------

// File: rtl/trap_ctl.sv
// Machine-mode trap sequencer: ecall/mret/external irq -> CSR update, flush, redirect handshake.
// Build option: define TRAP_CTL_IRQ_EN to compile in the external-interrupt path.
module trap_ctl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid_m,
  input  logic [31:0] i_pc_m,
  input  logic        i_ecall_m,
  input  logic        i_mret_m,
  input  logic        i_csr_wr_m,
  input  logic [11:0] i_csr_addr_m,
  input  logic [31:0] i_csr_wdata_m,
  input  logic        i_ext_irq,
  input  logic        i_redirect_ready,
  output logic        o_flush_exception,
  output logic        o_stall,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc,
  output logic [31:0] o_mcause,
  output logic [31:0] o_mstatus
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state, state_n;
  logic        mie, mpie, mie_n, mpie_n;
  logic        flush_n, stall_n, rvalid_n;
  logic [31:0] rpc_n, mtvec_n, mepc_n, mcause_n;
  logic        irq_take;

`ifdef TRAP_CTL_IRQ_EN
  assign irq_take = i_ext_irq & mie;
`else
  logic unused_irq;
  assign unused_irq = i_ext_irq;
  assign irq_take   = 1'b0;
`endif

  assign o_mstatus = {24'd0, mpie, 3'd0, mie, 3'd0};

  always_comb begin
    state_n  = state;
    flush_n  = 1'b0;
    stall_n  = o_stall;
    rvalid_n = o_redirect_valid;
    rpc_n    = o_redirect_pc;
    mtvec_n  = o_mtvec;
    mepc_n   = o_mepc;
    mcause_n = o_mcause;
    mie_n    = mie;
    mpie_n   = mpie;
    case (state)
      IDLE: begin
        stall_n  = 1'b0;
        rvalid_n = 1'b0;
        if (i_valid_m) begin
          // Trap priority: mret > ecall > irq; any trap drops a coincident CSR write.
          if (i_mret_m) begin
            rpc_n  = o_mepc;
            mie_n  = mpie;
            mpie_n = 1'b1;
          end else if (i_ecall_m || irq_take) begin
            rpc_n    = o_mtvec;
            mepc_n   = i_pc_m;
            mcause_n = i_ecall_m ? 32'd11 : 32'h8000_000B;
            mpie_n   = mie;
            mie_n    = 1'b0;
          end else if (i_csr_wr_m) begin
            case (i_csr_addr_m)
              12'h300: begin
                mie_n  = i_csr_wdata_m[3];
                mpie_n = i_csr_wdata_m[7];
              end
              12'h305: mtvec_n  = {i_csr_wdata_m[31:2], 2'b00};
              12'h341: mepc_n   = {i_csr_wdata_m[31:2], 2'b00};
              12'h342: mcause_n = i_csr_wdata_m;
              default: ;
            endcase
          end
          if (i_mret_m || i_ecall_m || irq_take) begin
            state_n = FLUSH;
            flush_n = 1'b1;
            stall_n = 1'b1;
          end
        end
      end
      FLUSH: begin
        state_n  = REDIRECT;
        stall_n  = 1'b1;
        rvalid_n = 1'b1;
      end
      REDIRECT: begin
        if (i_redirect_ready) begin
          state_n  = IDLE;
          stall_n  = 1'b0;
          rvalid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE;
      o_flush_exception <= 1'b0;
      o_stall           <= 1'b0;
      o_redirect_valid  <= 1'b0;
      o_redirect_pc     <= 32'd0;
      o_mtvec           <= RESET_MTVEC;
      o_mepc            <= 32'd0;
      o_mcause          <= 32'd0;
      mie               <= 1'b0;
      mpie              <= 1'b0;
    end else begin
      state             <= state_n;
      o_flush_exception <= flush_n;
      o_stall           <= stall_n;
      o_redirect_valid  <= rvalid_n;
      o_redirect_pc     <= rpc_n;
      o_mtvec           <= mtvec_n;
      o_mepc            <= mepc_n;
      o_mcause          <= mcause_n;
      mie               <= mie_n;
      mpie              <= mpie_n;
    end
  end

endmodule

// File: tb/tb_trap_ctl.sv
// Self-checking bench for trap_ctl: directed vector table, hand sequences, randomized ops vs model.
module tb_trap_ctl;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_valid_m = 0, i_ecall_m = 0, i_mret_m = 0, i_csr_wr_m = 0, i_ext_irq = 0;
  logic        i_redirect_ready = 0;
  logic [31:0] i_pc_m = 0, i_csr_wdata_m = 0;
  logic [11:0] i_csr_addr_m = 0;
  logic        o_flush_exception, o_stall, o_redirect_valid;
  logic [31:0] o_redirect_pc, o_mtvec, o_mepc, o_mcause, o_mstatus;

  trap_ctl #(.RESET_MTVEC(32'h0000_0100)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_m(i_valid_m), .i_pc_m(i_pc_m),
    .i_ecall_m(i_ecall_m), .i_mret_m(i_mret_m), .i_csr_wr_m(i_csr_wr_m),
    .i_csr_addr_m(i_csr_addr_m), .i_csr_wdata_m(i_csr_wdata_m), .i_ext_irq(i_ext_irq),
    .i_redirect_ready(i_redirect_ready), .o_flush_exception(o_flush_exception),
    .o_stall(o_stall), .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_mtvec(o_mtvec), .o_mepc(o_mepc), .o_mcause(o_mcause), .o_mstatus(o_mstatus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v, ec, mr, wr, irq;
    logic [11:0] a;
    logic [31:0] wd, pc;
    int          dly;
    logic        trap;
    logic [31:0] tgt, mtvec, mepc, mcause, mstatus;
  } vec_t;

  int n_cmp = 0, n_err = 0;

  // Architectural model state
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic        m_mie, m_mpie;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, ec, mr, wr, irq, logic [11:0] a, logic [31:0] wd, pc,
                              int dly, logic trap, logic [31:0] tgt, mtvec, mepc, mcause, mstatus);
    vec_t t;
    t.v = v; t.ec = ec; t.mr = mr; t.wr = wr; t.irq = irq; t.a = a; t.wd = wd; t.pc = pc;
    t.dly = dly; t.trap = trap; t.tgt = tgt; t.mtvec = mtvec; t.mepc = mepc;
    t.mcause = mcause; t.mstatus = mstatus;
    return t;
  endfunction

  task automatic model_reset();
    m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mie = 0; m_mpie = 0;
  endtask

  // Applies the architectural trap/CSR rules to one IDLE-cycle instruction and fills expectations.
  task automatic model_step(inout vec_t t);
    logic irq_en;
`ifdef TRAP_CTL_IRQ_EN
    irq_en = 1'b1;
`else
    irq_en = 1'b0;
`endif
    t.trap = 0; t.tgt = 0;
    if (t.v) begin
      if (t.mr) begin
        t.trap = 1; t.tgt = m_mepc; m_mie = m_mpie; m_mpie = 1;
      end else if (t.ec || (irq_en && t.irq && m_mie)) begin
        t.trap = 1; t.tgt = m_mtvec; m_mepc = t.pc;
        m_mcause = t.ec ? 32'd11 : 32'h8000_000B;
        m_mpie = m_mie; m_mie = 0;
      end else if (t.wr) begin
        if (t.a == 12'h300) begin m_mie = t.wd[3]; m_mpie = t.wd[7]; end
        else if (t.a == 12'h305) m_mtvec = t.wd & 32'hFFFF_FFFC;
        else if (t.a == 12'h341) m_mepc = t.wd & 32'hFFFF_FFFC;
        else if (t.a == 12'h342) m_mcause = t.wd;
      end
    end
    t.mtvec = m_mtvec; t.mepc = m_mepc; t.mcause = m_mcause;
    t.mstatus = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
  endtask

  task automatic drive(input vec_t t);
    i_valid_m = t.v; i_ecall_m = t.ec; i_mret_m = t.mr; i_csr_wr_m = t.wr; i_ext_irq = t.irq;
    i_csr_addr_m = t.a; i_csr_wdata_m = t.wd; i_pc_m = t.pc;
  endtask

  task automatic garbage();
    i_valid_m = 1'($urandom); i_ecall_m = 1'($urandom); i_mret_m = 1'($urandom);
    i_csr_wr_m = 1'($urandom); i_ext_irq = 1'($urandom); i_csr_addr_m = 12'h305;
    i_csr_wdata_m = $urandom; i_pc_m = $urandom;
  endtask

  task automatic idle_inputs();
    i_valid_m = 0; i_ecall_m = 0; i_mret_m = 0; i_csr_wr_m = 0; i_ext_irq = 0;
  endtask

  // One instruction in IDLE; if it traps, walk flush/redirect with t.dly cycles of ready low.
  task automatic run_op(input vec_t t, input string tag);
    drive(t);
    i_redirect_ready = 1'($urandom);
    @(posedge i_clk); #1;
    chk({tag, " flush"}, 32'(o_flush_exception), 32'(t.trap));
    chk({tag, " stall"}, 32'(o_stall), 32'(t.trap));
    chk({tag, " rvalid"}, 32'(o_redirect_valid), 0);
    chk({tag, " mtvec"}, o_mtvec, t.mtvec);
    chk({tag, " mepc"}, o_mepc, t.mepc);
    chk({tag, " mcause"}, o_mcause, t.mcause);
    chk({tag, " mstatus"}, o_mstatus, t.mstatus);
    if (t.trap) begin
      garbage();
      i_redirect_ready = 1'($urandom);
      @(posedge i_clk); #1;
      chk({tag, " flush_off"}, 32'(o_flush_exception), 0);
      chk({tag, " rvalid_on"}, 32'(o_redirect_valid), 1);
      chk({tag, " rpc"}, o_redirect_pc, t.tgt);
      for (int k = 0; k <= t.dly; k++) begin
        garbage();
        i_redirect_ready = (k == t.dly);
        @(posedge i_clk); #1;
        if (k < t.dly) begin
          chk({tag, " rvalid_hold"}, 32'(o_redirect_valid), 1);
          chk({tag, " rpc_hold"}, o_redirect_pc, t.tgt);
          chk({tag, " stall_hold"}, 32'(o_stall), 1);
        end else begin
          chk({tag, " rvalid_done"}, 32'(o_redirect_valid), 0);
          chk({tag, " stall_done"}, 32'(o_stall), 0);
        end
      end
      chk({tag, " mtvec_kept"}, o_mtvec, t.mtvec);
      chk({tag, " mstatus_kept"}, o_mstatus, t.mstatus);
    end
    idle_inputs();
    i_redirect_ready = 0;
  endtask

  vec_t tbl[11];
  vec_t t;
  logic [11:0] addrs[5];

  initial begin
    //            v ec mr wr irq addr    wdata      pc    dly trap tgt    mtvec  mepc   mcause        mstatus
    tbl[0]  = mk(1, 0, 0, 1, 0, 12'h300, 32'h08,    32'h0,  0, 0, 0,      32'h100, 0,      0,             32'h08);
    tbl[1]  = mk(1, 1, 0, 0, 0, 12'h0,   32'h0,     32'h40, 0, 1, 32'h100, 32'h100, 32'h40, 11,            32'h80);
    tbl[2]  = mk(1, 0, 1, 0, 0, 12'h0,   32'h0,     32'h44, 3, 1, 32'h40,  32'h100, 32'h40, 11,            32'h88);
    tbl[3]  = mk(1, 0, 0, 1, 0, 12'h305, 32'h203,   32'h48, 0, 0, 0,      32'h200, 32'h40, 11,            32'h88);
    tbl[4]  = mk(1, 1, 0, 0, 0, 12'h0,   32'h0,     32'h50, 0, 1, 32'h200, 32'h200, 32'h50, 11,            32'h80);
    tbl[5]  = mk(1, 1, 0, 1, 0, 12'h305, 32'h400,   32'h60, 1, 1, 32'h200, 32'h200, 32'h60, 11,            32'h00);
    tbl[6]  = mk(1, 0, 1, 0, 0, 12'h0,   32'h0,     32'h64, 0, 1, 32'h60,  32'h200, 32'h60, 11,            32'h80);
    tbl[7]  = mk(1, 0, 0, 1, 0, 12'h300, 32'h88,    32'h68, 0, 0, 0,      32'h200, 32'h60, 11,            32'h88);
    tbl[8]  = mk(0, 1, 0, 1, 1, 12'h305, 32'h500,   32'h6C, 0, 0, 0,      32'h200, 32'h60, 11,            32'h88);
`ifdef TRAP_CTL_IRQ_EN
    tbl[9]  = mk(1, 0, 0, 1, 1, 12'h305, 32'h600,   32'h80, 0, 1, 32'h200, 32'h200, 32'h80, 32'h8000_000B, 32'h80);
    tbl[10] = mk(1, 0, 1, 0, 0, 12'h0,   32'h0,     32'h90, 0, 1, 32'h80,  32'h200, 32'h80, 32'h8000_000B, 32'h88);
`else
    tbl[9]  = mk(1, 0, 0, 0, 1, 12'h0,   32'h0,     32'h80, 0, 0, 0,      32'h200, 32'h60, 11,            32'h88);
    tbl[10] = mk(1, 0, 1, 0, 0, 12'h0,   32'h0,     32'h90, 0, 1, 32'h60,  32'h200, 32'h60, 11,            32'h88);
`endif
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342; addrs[4] = 12'h7C0;

    // Reset state
    #12;
    chk("rst mtvec", o_mtvec, 32'h100);
    chk("rst mepc", o_mepc, 0);
    chk("rst mcause", o_mcause, 0);
    chk("rst mstatus", o_mstatus, 0);
    chk("rst flags", {29'd0, o_flush_exception, o_stall, o_redirect_valid}, 0);
    chk("rst rpc", o_redirect_pc, 0);
    @(negedge i_clk); i_rst = 0;
    model_reset();

    foreach (tbl[i]) begin
      t = tbl[i];
      run_op(tbl[i], $sformatf("vec%0d", i));
      model_step(t);
    end

    // Asynchronous reset while a redirect is outstanding
    t = mk(1, 1, 0, 0, 0, 12'h0, 32'h0, 32'h70, 0, 0, 0, 0, 0, 0, 0);
    drive(t);
    @(posedge i_clk); #1;
    idle_inputs();
    @(posedge i_clk); #1;
    chk("rstmid rvalid_on", 32'(o_redirect_valid), 1);
    i_rst = 1; #1;
    chk("rstmid rvalid", 32'(o_redirect_valid), 0);
    chk("rstmid stall", 32'(o_stall), 0);
    chk("rstmid mtvec", o_mtvec, 32'h100);
    chk("rstmid mstatus", o_mstatus, 0);
    @(negedge i_clk); i_rst = 0;
    model_reset();
    t = mk(1, 1, 0, 0, 0, 12'h0, 32'h0, 32'h74, 0, 0, 0, 0, 0, 0, 0);
    model_step(t);
    run_op(t, "post_rst ecall");

    // Randomized ops against the model
    for (int n = 0; n < 300; n++) begin
      t.v = ($urandom_range(3) != 0);
      t.ec = ($urandom_range(4) == 0);
      t.mr = ($urandom_range(5) == 0);
      t.wr = 1'($urandom);
      t.irq = ($urandom_range(2) == 0);
      t.a = addrs[$urandom_range(4)];
      t.wd = $urandom;
      t.pc = $urandom;
      t.dly = $urandom_range(3);
      model_step(t);
      run_op(t, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
